down_timer: RTL and testbench
=============================

# down_timer

Programmable down-counting timer with reload register, one-shot and auto-reload modes, pause/resume, and a one-cycle terminal-count strobe. It complements the team's up-counter-with-load: this block counts a loaded value down to zero instead of up from it. In the pong design it generates serve delays, paddle-speed ticks and frame-rate strobes from the shared clock-enable ticks.

## Interface
- bit_width, 16, width of reload register, count and dIN/dOUT.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clk_en  input  1  count tick; gates decrements only.
- load_en  input  1  load dIN into reload register and count; not gated by clk_en.
- dIN  input  bit_width  reload value.
- start  input  1  start, resume or retrigger.
- stop  input  1  pause counting.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at each terminal tick.
- dOUT  output  bit_width  current count.
- busy  output  1  high in RUN or HOLD.
- done  output  1  registered terminal-count strobe, exactly one clk cycle wide.
- wraps  output  8  saturating count of terminal ticks since last load.

## Operation
- Registers: Reload, Count, state, done, wraps.
- States: IDLE, RUN, HOLD, DONE.
- Edge priority, highest first: rst, load_en, stop, start, clk_en decrement.
- rst (async): state IDLE; Reload, Count, wraps = 0; done = 0; busy = 0.
- load_en, any state: Reload = dIN, Count = dIN, wraps = 0, state IDLE. No done pulse.
- stop:
  - RUN → HOLD; Count frozen.
  - Ignored in other states.
  - When start and stop are high on the same edge, stop wins: RUN → HOLD, and other states are unchanged.
- start when Reload == 0: ignored in every state, including IDLE.
- start with Reload != 0:
  - IDLE → RUN; Count unchanged.
  - DONE → RUN; Count = Reload.
  - HOLD → RUN; Count unchanged (resume).
  - RUN → RUN; Count = Reload (retrigger).
  - clk_en on the start edge does not decrement.
- RUN with clk_en = 1, no higher-priority event:
  - Count > 1: Count = Count - 1.
  - Count == 1 is the terminal tick. done = 1 on that edge, and wraps increments, saturating at 255.
  - Terminal tick with auto_reload = 1: Count = Reload, stay RUN.
  - Terminal tick with auto_reload = 0: Count = 0, state DONE.
- RUN with Count == 0 (IDLE loaded with 0 cannot start, so this is unreachable): treated as terminal tick.
- done is cleared on every edge where no terminal tick occurs.
- Outputs: dOUT = Count; busy = (state == RUN or HOLD). Both are combinational from registers.
- Arithmetic: unsigned, bit_width bits. No borrow past 0. Period is exactly Reload clk_en ticks.

## Timing
- Reset values: dOUT 0, busy 0, done 0, wraps 0.
- Load latency: dOUT = dIN on the edge where load_en is sampled high.
- Start latency: busy rises on the start edge. First decrement occurs at the first later edge with clk_en = 1.
- One-shot load N, start, clk_en constant 1:
  - dOUT sequence after start edge: N, N-1, …, 1, 0.
  - done and busy-fall coincide with dOUT reaching 0, N edges after start.
- Auto-reload: done every Reload clk_en ticks. dOUT sequence N…1, N…1 and so on, never showing 0.
- done is high for exactly one clk cycle regardless of clk_en duty.
- Async rst mid-operation clears all outputs without waiting for a clock edge. Deassertion is synchronous-safe: first action occurs on the following edge.
- auto_reload changes take effect only at the next terminal tick.

## Test plan
- One-shot (bit_width=8, clk_en=1):
  - Stimulus: rst; load 5; start.
  - Required: dOUT 5,4,3,2,1,0; done high one cycle coincident with dOUT=0; busy falls same edge; wraps=1; stays 0 for 10 further cycles.
- Auto-reload:
  - Stimulus: load 3; auto_reload=1; start; 9 ticks.
  - Required: dOUT 3,2,1,3,2,1,3,2,1; done pulses after ticks 3, 6, 9; wraps=3.
  - Follow-up: deassert auto_reload before tick 12; at tick 12 dOUT=0 and state DONE.
- Half-rate tick:
  - Stimulus: clk_en toggles every cycle; load 4; start.
  - Required: done occurs 8 clk edges after start, ±1 for tick phase; done still exactly one clk wide.
- Pause/resume:
  - Stimulus: load 6; start; stop when dOUT=2; hold 5 cycles; then start.
  - Required: during hold, dOUT stays 2 and busy=1. After start, dOUT goes 1, 0 with done.
  - Follow-up: start while RUN at dOUT=3 retriggers to 6.
- Priority and corner cases:
  - load_en=1 with dIN=9 mid-run → dOUT=9, busy=0, no done, wraps=0.
  - start and stop on the same edge in RUN → HOLD.
  - load 0 then start → stays IDLE, busy=0.
  - wraps saturates at 255 with load 1 in auto mode for 300 ticks.
- Async reset: assert rst between clock edges mid-run at dOUT=7 → dOUT, busy, done and wraps all 0 immediately.

Source files
------------

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: load/start/stop/tick controls in,
// count, busy, terminal strobe and wrap count out.
interface down_timer_if #(parameter int bit_width = 16);
  logic                 clk_en;
  logic                 load_en;
  logic [bit_width-1:0] dIN;
  logic                 start;
  logic                 stop;
  logic                 auto_reload;
  logic [bit_width-1:0] dOUT;
  logic                 busy;
  logic                 done;
  logic [7:0]           wraps;

  modport master (
    output clk_en, load_en, dIN, start, stop, auto_reload,
    input  dOUT, busy, done, wraps
  );

  modport slave (
    input  clk_en, load_en, dIN, start, stop, auto_reload,
    output dOUT, busy, done, wraps
  );
endinterface

// File: rtl/down_timer.sv
// Programmable down-counter with reload register, one-shot / auto-reload
// modes, pause/resume and a single-cycle terminal-count strobe.
module down_timer #(
  parameter int bit_width = 16
) (
  input  logic        clk,
  input  logic        rst,
  down_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t               state, state_nxt;
  logic [bit_width-1:0] reload, reload_nxt;
  logic [bit_width-1:0] count, count_nxt;
  logic                 done, done_nxt;
  logic [7:0]           wraps, wraps_nxt;
  logic                 terminal;

  // Count of 0 in RUN is unreachable but is handled as terminal so it can never borrow.
  assign terminal = (count <= bit_width'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      reload <= '0;
      count  <= '0;
      done   <= 1'b0;
      wraps  <= '0;
    end else begin
      state  <= state_nxt;
      reload <= reload_nxt;
      count  <= count_nxt;
      done   <= done_nxt;
      wraps  <= wraps_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    reload_nxt = reload;
    count_nxt  = count;
    done_nxt   = 1'b0;
    wraps_nxt  = wraps;
    if (bus.load_en) begin
      reload_nxt = bus.dIN;
      count_nxt  = bus.dIN;
      wraps_nxt  = '0;
      state_nxt  = IDLE;
    end else if (bus.stop) begin
      // stop masks a simultaneous start in every state
      if (state == RUN) state_nxt = HOLD;
    end else if (bus.start && (reload != '0)) begin
      state_nxt = RUN;
      if (state == DONE || state == RUN) count_nxt = reload;
    end else if (state == RUN && bus.clk_en) begin
      if (terminal) begin
        done_nxt  = 1'b1;
        wraps_nxt = (wraps == 8'hFF) ? wraps : wraps + 8'd1;
        if (bus.auto_reload) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = DONE;
        end
      end else begin
        count_nxt = count - bit_width'(1);
      end
    end
  end

  assign bus.dOUT  = count;
  assign bus.busy  = (state == RUN) || (state == HOLD);
  assign bus.done  = done;
  assign bus.wraps = wraps;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: vector table for one-shot and auto-reload,
// hand sequences for half-rate tick, pause/resume, priority, saturation, async reset.
module tb_down_timer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  down_timer_if #(.bit_width(W)) bus();
  down_timer #(.bit_width(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         ld;
    logic [W-1:0] din;
    logic         st, sp, ce, ar;
    logic [W-1:0] dout;
    logic         busy, done;
    logic [7:0]   wraps;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic ld, input logic [W-1:0] din,
                              input logic st, sp, ce, ar,
                              input logic [W-1:0] dout, input logic busy, done,
                              input logic [7:0] wraps);
    vec_t v;
    v.ld = ld; v.din = din; v.st = st; v.sp = sp; v.ce = ce; v.ar = ar;
    v.dout = dout; v.busy = busy; v.done = done; v.wraps = wraps;
    return v;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic expect4(input string nm, input int dout, input int busy,
                         input int done, input int wraps);
    check({nm, ".dOUT"},  int'(bus.dOUT),  dout);
    check({nm, ".busy"},  int'(bus.busy),  busy);
    check({nm, ".done"},  int'(bus.done),  done);
    check({nm, ".wraps"}, int'(bus.wraps), wraps);
  endtask

  // Inputs are applied mid-cycle, then sampled 1 time unit after the edge.
  task automatic drive(input logic ld, input logic [W-1:0] din,
                       input logic st, sp, ce, ar);
    bus.load_en = ld; bus.dIN = din; bus.start = st;
    bus.stop = sp; bus.clk_en = ce; bus.auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    bit seen;
    bus.load_en = 0; bus.dIN = '0; bus.start = 0;
    bus.stop = 0; bus.clk_en = 0; bus.auto_reload = 0;

    // one-shot load 5
    vt.push_back(mk(1, 5, 0, 0, 1, 0,  5, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 1, 0,  5, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  4, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  3, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  2, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
    // auto-reload load 3, then one-shot from tick 10
    vt.push_back(mk(1, 3, 0, 0, 1, 1,  3, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 1, 1,  3, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  2, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  2, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 2));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  2, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  1, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 3));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  2, 1, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  1, 1, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 4));
    vt.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 4));

    #12;
    expect4("reset", 0, 0, 0, 0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ld, vt[i].din, vt[i].st, vt[i].sp, vt[i].ce, vt[i].ar);
      expect4($sformatf("vec%0d", i), vt[i].dout, vt[i].busy, vt[i].done, vt[i].wraps);
    end

    // one-shot stays finished
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      expect4($sformatf("after_done%0d", i), 0, 0, 0, 4);
    end

    // half-rate tick: start with clk_en low, then toggle
    drive(1, 4, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    expect4("half.start", 4, 1, 0, 0);
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin
      drive(0, 0, 0, 0, (edges % 2 == 0), 0);
      edges++;
      seen = bus.done;
    end
    check("half.done_seen", int'(seen), 1);
    check("half.edges_in_window", int'(edges >= 7 && edges <= 9), 1);
    check("half.dout_at_done", int'(bus.dOUT), 0);
    drive(0, 0, 0, 0, 1, 0);
    check("half.done_one_wide", int'(bus.done), 0);

    // pause at 2, resume
    drive(1, 6, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    for (int v = 5; v >= 2; v--) drive(0, 0, 0, 0, 1, 0);
    expect4("pause.pre", 2, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    expect4("pause.stop", 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      expect4($sformatf("pause.hold%0d", i), 2, 1, 0, 0);
    end
    drive(0, 0, 1, 0, 1, 0);
    expect4("pause.resume", 2, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    expect4("pause.r1", 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    expect4("pause.r0", 0, 0, 1, 1);

    // retrigger at 3 (from DONE start reloads to 6)
    drive(0, 0, 1, 0, 1, 0);
    expect4("retrig.start", 6, 1, 0, 1);
    for (int v = 5; v >= 3; v--) drive(0, 0, 0, 0, 1, 0);
    expect4("retrig.at3", 3, 1, 0, 1);
    drive(0, 0, 1, 0, 1, 0);
    expect4("retrig.reload", 6, 1, 0, 1);

    // start and stop together in RUN: HOLD
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 1, 0);
    expect4("startstop.edge", 5, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    expect4("startstop.held", 5, 1, 0, 1);

    // load 0 cannot start
    drive(1, 0, 0, 0, 1, 0);
    expect4("zero.load", 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0);
    expect4("zero.start", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    expect4("zero.after", 0, 0, 0, 0);

    // wraps saturation, then load mid-run on a would-be terminal tick
    drive(1, 1, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 1, 1);
    expect4("sat", 1, 1, 1, 255);
    drive(1, 9, 0, 0, 1, 1);
    expect4("load_midrun", 9, 0, 0, 0);

    // async reset at dOUT=7
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1);
    expect4("arst.pre", 7, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect4("arst.now", 0, 0, 0, 0);
    #3 rst = 1'b0;
    drive(0, 0, 1, 0, 1, 0);
    expect4("arst.after", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
